// File: rtl/sr_ff_bank.sv
// sr_ff_bank: a bank of WIDTH clocked flip-flop channels with a per-bank mode
// select (SR, JK, D, T). The forbidden SR input (s=r=1) is resolved by the
// POLICY parameter. Each occurrence is flagged in a sticky per-channel err bit
// and counted by a saturating counter.
//
// Optional feature: define SR_FF_BANK_IRQ_EN to add a registered single-cycle
// irq pulse. It fires when the OR of err rises from 0 to nonzero.
module sr_ff_bank #(
  parameter int               WIDTH   = 4,
  parameter int               CNT_W   = 8,
  parameter int               POLICY  = 0,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] r,
  input  logic             err_clr,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qnot,
  output logic [WIDTH-1:0] err,
  output logic [CNT_W-1:0] conflict_cnt
`ifdef SR_FF_BANK_IRQ_EN
  ,
  output logic             irq
`endif
);

  typedef enum logic [1:0] {
    MODE_SR = 2'b00,
    MODE_JK = 2'b01,
    MODE_D  = 2'b10,
    MODE_T  = 2'b11
  } mode_e;

  mode_e            mode_sel;
  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] conflict;
  logic [WIDTH-1:0] err_next;
  logic             any_conflict;
  logic [CNT_W-1:0] cnt_max;

  assign mode_sel     = mode_e'(mode);
  assign any_conflict = |conflict;
  assign cnt_max      = '1;

  // The complement output is derived straight from the register and is never a separate flop.
  assign qnot = ~q;

  // Per-channel next-state decode for the selected mode. This block also flags SR conflicts.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    q_next   = q;
    conflict = '0;
    if (en) begin
      for (int i = 0; i < WIDTH; i++) begin
        case (mode_sel)
          MODE_SR: begin
            case ({s[i], r[i]})
              2'b10:   q_next[i] = 1'b1;
              2'b01:   q_next[i] = 1'b0;
              2'b11: begin
                conflict[i] = 1'b1;
                if (POLICY == 1)      q_next[i] = 1'b1;
                else if (POLICY == 2) q_next[i] = 1'b0;
                else                  q_next[i] = q[i];
              end
              default: q_next[i] = q[i];
            endcase
          end
          MODE_JK: begin
            case ({s[i], r[i]})
              2'b10:   q_next[i] = 1'b1;
              2'b01:   q_next[i] = 1'b0;
              2'b11:   q_next[i] = ~q[i];
              default: q_next[i] = q[i];
            endcase
          end
          MODE_D:  q_next[i] = s[i];
          MODE_T:  q_next[i] = q[i] ^ s[i];
          default: q_next[i] = q[i];
        endcase
      end
    end
  end

  // Sticky error flags. A conflict on the same edge as err_clr takes priority over the clear.
  always_comb begin
    if (err_clr) err_next = conflict;
    else         err_next = err | conflict;
  end

  // State register bank.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    if (!rst_n) q <= RST_VAL;
    else        q <= q_next;
  end

  // Error flags and the saturating count of edges that carried at least one conflict.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err          <= '0;
      conflict_cnt <= '0;
    end else begin
      err <= err_next;
      if (err_clr)
        conflict_cnt <= any_conflict ? CNT_W'(1) : '0;
      else if (any_conflict && conflict_cnt != cnt_max)
        conflict_cnt <= conflict_cnt + CNT_W'(1);
    end
  end

`ifdef SR_FF_BANK_IRQ_EN
  // Pulse for one cycle when the aggregate error goes from clear to set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) irq <= 1'b0;
    else        irq <= (err == '0) && (err_next != '0);
  end
`endif

endmodule

// File: tb/tb_sr_ff_bank.sv
// Directed testbench for sr_ff_bank. Three instances share one stimulus:
// u_a (POLICY 0, CNT_W 2, RST_VAL 1010), u_b (POLICY 1) and u_c (POLICY 2).
module tb_sr_ff_bank;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [1:0] mode;
  logic [3:0] s;
  logic [3:0] r;
  logic       err_clr;

  logic [3:0] q_a, qn_a, err_a;
  logic [1:0] cnt_a;
  logic [3:0] q_b, qn_b, err_b;
  logic [7:0] cnt_b;
  logic [3:0] q_c, qn_c, err_c;
  logic [7:0] cnt_c;
`ifdef SR_FF_BANK_IRQ_EN
  logic       irq_a, irq_b, irq_c;
`endif

  int compared   = 0;
  int mismatched = 0;

  localparam logic [1:0] M_SR = 2'b00, M_JK = 2'b01, M_D = 2'b10, M_T = 2'b11;

  sr_ff_bank #(.WIDTH(4), .CNT_W(2), .POLICY(0), .RST_VAL(4'b1010)) u_a (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .s(s), .r(r), .err_clr(err_clr),
    .q(q_a), .qnot(qn_a), .err(err_a), .conflict_cnt(cnt_a)
`ifdef SR_FF_BANK_IRQ_EN
    , .irq(irq_a)
`endif
  );

  sr_ff_bank #(.WIDTH(4), .CNT_W(8), .POLICY(1), .RST_VAL(4'b0000)) u_b (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .s(s), .r(r), .err_clr(err_clr),
    .q(q_b), .qnot(qn_b), .err(err_b), .conflict_cnt(cnt_b)
`ifdef SR_FF_BANK_IRQ_EN
    , .irq(irq_b)
`endif
  );

  sr_ff_bank #(.WIDTH(4), .CNT_W(8), .POLICY(2), .RST_VAL(4'b0000)) u_c (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .s(s), .r(r), .err_clr(err_clr),
    .q(q_c), .qnot(qn_c), .err(err_c), .conflict_cnt(cnt_c)
`ifdef SR_FF_BANK_IRQ_EN
    , .irq(irq_c)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply one set of inputs, then advance to 1 time unit past the next rising edge.
  task automatic apply(input logic e, input logic [1:0] m, input logic [3:0] sv,
                       input logic [3:0] rv, input logic clr);
    en = e; mode = m; s = sv; r = rv; err_clr = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    apply(1'b1, M_D, 4'b0000, 4'b0000, 1'b0);
    rst_n = 1'b1;
    apply(1'b1, M_D, 4'b0101, 4'b0000, 1'b0);  // load 0101 so that reset is visible
    compared++; if (q_a !== 4'b0101) begin mismatched++; $display("FAIL pre_reset_load q_a=%b exp=0101", q_a); end
    // Assert reset mid-cycle and check before any clock edge arrives.
    #2 rst_n = 1'b0;
    #1;
    compared++; if (q_a !== 4'b1010) begin mismatched++; $display("FAIL async_reset q_a=%b exp=1010", q_a); end
    compared++; if (qn_a !== 4'b0101) begin mismatched++; $display("FAIL async_reset qnot_a=%b exp=0101", qn_a); end
    compared++; if (err_a !== 4'b0000 || cnt_a !== 2'd0) begin mismatched++; $display("FAIL async_reset err_a=%b cnt_a=%0d exp=0000/0", err_a, cnt_a); end
    compared++; if (q_b !== 4'b0000 || qn_b !== 4'b1111) begin mismatched++; $display("FAIL async_reset q_b=%b qnot_b=%b exp=0000/1111", q_b, qn_b); end
`ifdef SR_FF_BANK_IRQ_EN
    compared++; if (irq_a !== 1'b0) begin mismatched++; $display("FAIL async_reset irq_a=%b exp=0", irq_a); end
`endif
    // Reset must dominate an active D load across an edge.
    apply(1'b1, M_D, 4'b1111, 4'b0000, 1'b0);
    compared++; if (q_a !== 4'b1010) begin mismatched++; $display("FAIL reset_dominates q_a=%b exp=1010", q_a); end
    rst_n = 1'b1;
    apply(1'b1, M_D, 4'b0000, 4'b0000, 1'b0);   // first edge after release performs the update
    compared++; if (q_a !== 4'b0000) begin mismatched++; $display("FAIL reset_release q_a=%b exp=0000", q_a); end
  endtask

  task automatic test_sr;
    apply(1'b1, M_SR, 4'b0011, 4'b0000, 1'b0);
    compared++; if (q_a !== 4'b0011) begin mismatched++; $display("FAIL sr_set q_a=%b exp=0011", q_a); end
    apply(1'b1, M_SR, 4'b0000, 4'b0001, 1'b0);
    compared++; if (q_a !== 4'b0010) begin mismatched++; $display("FAIL sr_reset q_a=%b exp=0010", q_a); end
    apply(1'b1, M_SR, 4'b0100, 4'b0100, 1'b0);
    compared++; if (q_a !== 4'b0010) begin mismatched++; $display("FAIL sr_conflict_hold q_a=%b exp=0010", q_a); end
    compared++; if (err_a !== 4'b0100) begin mismatched++; $display("FAIL sr_conflict_err err_a=%b exp=0100", err_a); end
    compared++; if (cnt_a !== 2'd1) begin mismatched++; $display("FAIL sr_conflict_cnt cnt_a=%0d exp=1", cnt_a); end
  endtask

  task automatic test_policy;
    apply(1'b1, M_D, 4'b0000, 4'b0000, 1'b1);  // q=0000 everywhere, err/cnt cleared
    apply(1'b1, M_SR, 4'b1111, 4'b1111, 1'b0);
    compared++; if (q_b !== 4'b1111) begin mismatched++; $display("FAIL policy_set q_b=%b exp=1111", q_b); end
    compared++; if (q_c !== 4'b0000) begin mismatched++; $display("FAIL policy_reset q_c=%b exp=0000", q_c); end
    compared++; if (q_a !== 4'b0000) begin mismatched++; $display("FAIL policy_hold q_a=%b exp=0000", q_a); end
    compared++; if (err_b !== 4'b1111 || err_c !== 4'b1111) begin mismatched++; $display("FAIL policy_err err_b=%b err_c=%b exp=1111", err_b, err_c); end
    compared++; if (cnt_b !== 8'd1 || cnt_c !== 8'd1) begin mismatched++; $display("FAIL policy_cnt cnt_b=%0d cnt_c=%0d exp=1", cnt_b, cnt_c); end
  endtask

  task automatic test_jk_t;
    logic [3:0] exp_jk [3];
    exp_jk[0] = 4'b1111; exp_jk[1] = 4'b0000; exp_jk[2] = 4'b1111;
    apply(1'b1, M_D, 4'b0000, 4'b0000, 1'b1);
    compared++; if (err_a !== 4'b0000 || cnt_a !== 2'd0) begin mismatched++; $display("FAIL clear_alone err_a=%b cnt_a=%0d exp=0000/0", err_a, cnt_a); end
    for (int i = 0; i < 3; i++) begin
      apply(1'b1, M_JK, 4'b1111, 4'b1111, 1'b0);
      compared++; if (q_a !== exp_jk[i] || err_a !== 4'b0000) begin mismatched++; $display("FAIL jk_toggle[%0d] q_a=%b err_a=%b exp=%b/0000", i, q_a, err_a, exp_jk[i]); end
    end
    apply(1'b1, M_JK, 4'b1100, 4'b0110, 1'b0);   // ch3 set, ch2 toggle, ch1 reset, ch0 hold
    compared++; if (q_a !== 4'b1001) begin mismatched++; $display("FAIL jk_mixed q_a=%b exp=1001", q_a); end
    apply(1'b1, M_D, 4'b1111, 4'b0000, 1'b0);
    apply(1'b1, M_T, 4'b0101, 4'b0000, 1'b0);
    compared++; if (q_a !== 4'b1010) begin mismatched++; $display("FAIL t_first q_a=%b exp=1010", q_a); end
    apply(1'b1, M_T, 4'b0101, 4'b0000, 1'b0);
    compared++; if (q_a !== 4'b1111) begin mismatched++; $display("FAIL t_second q_a=%b exp=1111", q_a); end
  endtask

  task automatic test_saturation;
    logic [1:0] exp_cnt [5];
    exp_cnt[0] = 2'd1; exp_cnt[1] = 2'd2; exp_cnt[2] = 2'd3; exp_cnt[3] = 2'd3; exp_cnt[4] = 2'd3;
    apply(1'b1, M_D, 4'b0110, 4'b0000, 1'b1);  // q_a=0110, counters cleared
    for (int i = 0; i < 5; i++) begin
      apply(1'b1, M_SR, 4'b1111, 4'b1111, 1'b0);
      compared++; if (cnt_a !== exp_cnt[i]) begin mismatched++; $display("FAIL sat_cnt[%0d] cnt_a=%0d exp=%0d", i, cnt_a, exp_cnt[i]); end
    end
    compared++; if (cnt_b !== 8'd5) begin mismatched++; $display("FAIL wide_cnt cnt_b=%0d exp=5", cnt_b); end
    apply(1'b1, M_SR, 4'b0000, 4'b0000, 1'b1);
    compared++; if (cnt_a !== 2'd0 || err_a !== 4'b0000) begin mismatched++; $display("FAIL clr_alone cnt_a=%0d err_a=%b exp=0/0000", cnt_a, err_a); end
    compared++; if (q_a !== 4'b0110) begin mismatched++; $display("FAIL clr_keeps_q q_a=%b exp=0110", q_a); end
    apply(1'b1, M_SR, 4'b0001, 4'b0001, 1'b0);
    apply(1'b1, M_SR, 4'b0001, 4'b0001, 1'b1);  // clear and conflict on the same edge
    compared++; if (cnt_a !== 2'd1 || err_a !== 4'b0001) begin mismatched++; $display("FAIL clr_vs_conflict cnt_a=%0d err_a=%b exp=1/0001", cnt_a, err_a); end
  endtask

  task automatic test_enable;
    apply(1'b0, M_SR, 4'b1111, 4'b1111, 1'b0);
    compared++; if (q_a !== 4'b0110 || err_a !== 4'b0001 || cnt_a !== 2'd1) begin mismatched++; $display("FAIL en_low_sr q_a=%b err_a=%b cnt_a=%0d exp=0110/0001/1", q_a, err_a, cnt_a); end
    apply(1'b0, M_D, 4'b0000, 4'b0000, 1'b0);
    compared++; if (q_b !== 4'b1111) begin mismatched++; $display("FAIL en_low_d q_b=%b exp=1111", q_b); end
  endtask

`ifdef SR_FF_BANK_IRQ_EN
  task automatic test_irq;
    apply(1'b1, M_D, 4'b0000, 4'b0000, 1'b1);
    compared++; if (irq_a !== 1'b0) begin mismatched++; $display("FAIL irq_on_clear irq_a=%b exp=0", irq_a); end
    apply(1'b1, M_SR, 4'b0001, 4'b0001, 1'b0);
    compared++; if (irq_a !== 1'b1) begin mismatched++; $display("FAIL irq_first irq_a=%b exp=1", irq_a); end
    apply(1'b1, M_SR, 4'b0000, 4'b0000, 1'b0);
    compared++; if (irq_a !== 1'b0) begin mismatched++; $display("FAIL irq_one_cycle irq_a=%b exp=0", irq_a); end
    apply(1'b1, M_SR, 4'b0010, 4'b0010, 1'b0);
    compared++; if (irq_a !== 1'b0) begin mismatched++; $display("FAIL irq_no_repulse irq_a=%b exp=0", irq_a); end
    apply(1'b1, M_SR, 4'b0100, 4'b0100, 1'b1);  // same-edge clear plus conflict
    compared++; if (irq_a !== 1'b0) begin mismatched++; $display("FAIL irq_clr_conflict irq_a=%b exp=0", irq_a); end
    apply(1'b1, M_SR, 4'b0000, 4'b0000, 1'b1);
    apply(1'b1, M_SR, 4'b1000, 4'b1000, 1'b0);
    compared++; if (irq_a !== 1'b1) begin mismatched++; $display("FAIL irq_repulse irq_a=%b exp=1", irq_a); end
    apply(1'b1, M_SR, 4'b0000, 4'b0000, 1'b0);
    compared++; if (irq_a !== 1'b0) begin mismatched++; $display("FAIL irq_repulse_end irq_a=%b exp=0", irq_a); end
  endtask
`endif

  initial begin
    rst_n = 1'b0; en = 1'b0; mode = M_SR; s = '0; r = '0; err_clr = 1'b0;
    test_reset();
    test_sr();
    test_policy();
    test_jk_t();
    test_saturation();
    test_enable();
`ifdef SR_FF_BANK_IRQ_EN
    test_irq();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
